softmax_sampler: RTL

// - Consumes the 40-bit exp() stream (one value per vocabulary entry) and draws one index with

---
 rtl/softmax_sampler.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/softmax_sampler.sv
`default_nettype none
//==============================================================================
// Module   : softmax_sampler
// Brief    : Buffers one vector of exp() values, then draws an index with
//            probability value/sum using a Galois LFSR and a cumulative scan.
//            The drawn index is the next token fed back to the NN input stage.
// Config   : SAMPLER_ARGMAX_EN - when defined, greedy decode (argmax, lowest
//            index wins ties) replaces the stochastic draw; no buffer, no LFSR.
// Revision : 1.0 - initial release
//==============================================================================
module softmax_sampler #(
    parameter int                N      = 128,
    parameter int                IDX_W  = 7,
    parameter int                DW     = 40,
    parameter int                SW     = 48,
    parameter int                RAND_W = 16,
    parameter logic [RAND_W-1:0] SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic             ovf
);

    // Beat counter needs one extra bit so it can reach N and flag overflow.
    localparam int                 c_cnt_w = IDX_W + 1;
    localparam logic [c_cnt_w-1:0] c_n     = c_cnt_w'(N);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAW  = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_idx;
    logic               r_ovf;
    logic [c_cnt_w-1:0] r_count;

    logic               w_accept;
    logic               w_room;
    logic               w_store;

    // in_ready is only high in ACCUM, so any accepted beat belongs to ACCUM.
    assign w_accept  = in_valid & r_in_ready;
    assign w_room    = (r_count < c_n);
    assign w_store   = w_accept & w_room;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign ovf       = r_ovf;

`ifdef SAMPLER_ARGMAX_EN

    logic [DW-1:0]    r_max_val;
    logic [IDX_W-1:0] r_max_idx;
    logic             w_gt;
    logic [IDX_W-1:0] w_max_idx_next;

    // Strict greater-than keeps the earliest index on ties; a zero vector
    // never beats the cleared maximum and therefore reports index 0.
    assign w_gt           = (in_data > r_max_val);
    assign w_max_idx_next = (w_store && w_gt) ? r_count[IDX_W-1:0] : r_max_idx;

    // Greedy decode control: track the running maximum, report on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_max_val   <= '0;
            r_max_idx   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_room) begin
                            r_count <= r_count + c_one;
                            if (w_gt) begin
                                r_max_val <= in_data;
                                r_max_idx <= r_count[IDX_W-1:0];
                            end
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        if (in_last) begin
                            r_out_idx   <= w_max_idx_next;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_max_val   <= '0;
                        r_max_idx   <= '0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`else

    localparam logic [RAND_W-1:0] c_lfsr_mask = RAND_W'(16'hB400);

    logic [DW-1:0]      r_mem [N];
    logic [DW-1:0]      r_rd_data;
    logic [SW-1:0]      r_sum;
    logic [SW-1:0]      r_part;
    logic [SW-1:0]      r_thr;
    logic [RAND_W-1:0]  r_lfsr;
    logic [IDX_W-1:0]   r_scan_idx;

    logic [SW:0]        w_sum_ext;
    logic [SW-1:0]      w_sum_sat;
    logic [SW:0]        w_part_ext;
    logic [SW-1:0]      w_part_sat;
    logic [SW-1:0]      w_thr;
    logic [RAND_W-1:0]  w_lfsr_next;
    logic [IDX_W-1:0]   w_rd_addr;
    logic [c_cnt_w-1:0] w_last_idx;
    logic               w_scan_end;

    // Saturating accumulators: the carry-out bit selects the all-ones value.
    assign w_sum_ext  = {1'b0, r_sum} + {{(SW+1-DW){1'b0}}, in_data};
    assign w_sum_sat  = w_sum_ext[SW] ? {SW{1'b1}} : w_sum_ext[SW-1:0];
    assign w_part_ext = {1'b0, r_part} + {{(SW+1-DW){1'b0}}, r_rd_data};
    assign w_part_sat = w_part_ext[SW] ? {SW{1'b1}} : w_part_ext[SW-1:0];

    // Threshold is the random fraction lfsr/2^RAND_W of the sum, so it is
    // always strictly below a nonzero sum and some entry must exceed it.
    assign w_thr = SW'(({{SW{1'b0}}, r_lfsr} * {{RAND_W{1'b0}}, r_sum}) >> RAND_W);

    // Right-shifting Galois LFSR step.
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_mask) : (r_lfsr >> 1);

    // DRAW primes address 0; SCAN prefetches the entry after the one being compared.
    assign w_rd_addr  = (r_state == SCAN) ? (r_scan_idx + IDX_W'(1)) : '0;

    // Scan stops at the last stored entry if saturation prevented a hit.
    assign w_last_idx = r_count - c_one;
    assign w_scan_end = ({1'b0, r_scan_idx} == w_last_idx);

    // Vector buffer: written on stored beats, read synchronously during the scan
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_count[IDX_W-1:0]] <= in_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Sampler control: accumulate, draw threshold, scan cumulative sum, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_sum       <= '0;
            r_part      <= '0;
            r_thr       <= '0;
            r_scan_idx  <= '0;
            r_lfsr      <= SEED;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_room) begin
                            r_sum   <= w_sum_sat;
                            r_count <= r_count + c_one;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        if (in_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    r_thr      <= w_thr;
                    r_lfsr     <= w_lfsr_next;
                    r_part     <= '0;
                    r_scan_idx <= '0;
                    // Nothing to choose from: report index 0 without scanning.
                    if (r_sum == '0) begin
                        r_out_idx   <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_part <= w_part_sat;
                    if (w_part_sat > r_thr) begin
                        r_out_idx   <= r_scan_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_scan_end) begin
                        r_out_idx   <= w_last_idx[IDX_W-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_scan_idx <= r_scan_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_sum       <= '0;
                        r_count     <= '0;
                        r_part      <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`endif

endmodule
`default_nettype wire
